vga_frame_reader: RTL

//  Display-side stage after the camera capture path.
//  - Capture logic writes RGB444 pixels (addr 0..307199) into a dual-port BRAM framebuffer.
//  - This block reads that BRAM in raster order.
//  - It drives 640x480@60 VGA (25 MHz pixel clock): RGB444 plus HS/VS, pipeline-aligned to the BRAM read latency.
//  - Display is gated frame-by-frame by a frame_ready handshake from the capture side.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_sync_gen.sv | 61 ++++++
 rtl/vga_frame_reader.sv | 100 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the display-gating state type.
// Latency: n/a. Backpressure: n/a (constants only).
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
    localparam int RD_LAT   = 1;
    localparam int ADDR_W   = 19;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/vga_sync_gen.sv
// Raster counters with raw (stage 0) active/hsync/vsync and frame markers.
// Latency: outputs decode the current counter state combinationally.
// Backpressure: none; free-running at the pixel clock.
module vga_sync_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
) (
    input  logic clk,
    input  logic rst_n,
    output logic active,
    output logic hs_n,
    output logic vs_n,
    output logic first,
    output logic end_of_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    typedef logic [HW-1:0] hcnt_t;
    typedef logic [VW-1:0] vcnt_t;

    localparam hcnt_t H_LAST = hcnt_t'(H_TOTAL - 1);
    localparam hcnt_t H_ACT  = hcnt_t'(H_ACTIVE);
    localparam hcnt_t HS_BEG = hcnt_t'(H_ACTIVE + H_FP);
    localparam hcnt_t HS_END = hcnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam vcnt_t V_LAST = vcnt_t'(V_TOTAL - 1);
    localparam vcnt_t V_ACT  = vcnt_t'(V_ACTIVE);
    localparam vcnt_t VS_BEG = vcnt_t'(V_ACTIVE + V_FP);
    localparam vcnt_t VS_END = vcnt_t'(V_ACTIVE + V_FP + V_SYNC);

    hcnt_t h_cnt;
    vcnt_t v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_n         = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_n         = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    assign first        = (h_cnt == '0) && (v_cnt == '0);
    assign end_of_frame = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_frame_reader.sv
// Raster-order framebuffer reader driving VGA RGB444 + HS/VS, gated per frame by frame_ready.
// Latency: 2+RD_LAT cycles from raster position to pins (3 for RD_LAT=1), all outputs aligned.
// Backpressure: none; frame_ready is sampled only on the last cycle of each frame.
module vga_frame_reader #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int RD_LAT   = vga_timing_pkg::RD_LAT,
    parameter int ADDR_W   = vga_timing_pkg::ADDR_W
) (
    input  logic              PCLK_VGA,
    input  logic              rst,
    input  logic              frame_ready,
    input  logic [11:0]       rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              frame_start
);

    import vga_timing_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    logic   active, hs_n, vs_n, first, end_of_frame;
    logic   run;
    state_t state;

    logic [ADDR_W-1:0] addr_cnt;
    logic [RD_LAT:0]   act_dl, hs_dl, vs_dl, fs_dl;

    vga_sync_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_sync (
        .clk         (PCLK_VGA),
        .rst_n       (rst),
        .active      (active),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .first       (first),
        .end_of_frame(end_of_frame)
    );

    assign run = (state == RUN);

    // Delay-line index RD_LAT is the stage at which rd_data for that pixel is valid.
    always_ff @(posedge PCLK_VGA or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            rd_addr     <= '0;
            rd_en       <= 1'b0;
            act_dl      <= '0;
            hs_dl       <= '1;
            vs_dl       <= '1;
            fs_dl       <= '0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (end_of_frame) begin
                state <= frame_ready ? RUN : IDLE;
            end

            // Wrap after the last visible pixel so the counter never points past the buffer.
            if (end_of_frame) begin
                addr_cnt <= '0;
            end else if (active) begin
                addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
            end

            rd_addr <= addr_cnt;
            rd_en   <= active && run;

            act_dl <= {act_dl[RD_LAT-1:0], active && run};
            hs_dl  <= {hs_dl[RD_LAT-1:0], hs_n};
            vs_dl  <= {vs_dl[RD_LAT-1:0], vs_n};
            fs_dl  <= {fs_dl[RD_LAT-1:0], first && run};

            {VGA_R, VGA_G, VGA_B} <= act_dl[RD_LAT] ? rd_data : 12'h000;
            VGA_HS      <= hs_dl[RD_LAT];
            VGA_VS      <= vs_dl[RD_LAT];
            frame_start <= fs_dl[RD_LAT];
        end
    end

endmodule
